dot_product_accumulator: RTL and testbench

Sequential consumer of the Multiplier16x16 product. It accepts a stream of unsigned 16-bit operand pairs over a valid/ready handshake and registers each pair. The registered pair drives an internal Multiplier16x16 instance, and the 32-bit product P is accumulated over LEN pairs. Each completed dot product is presented on a valid/ready output with a sticky overflow flag.

---
 rtl/dot_product_accumulator.sv | 116 +++++++++++
 tb/tb_dot_product_accumulator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// Dot product of LEN unsigned 16x16 operand pairs, accumulated modulo 2^ACC_W with sticky carry flag.
// Latency: result valid one edge after the last pair is accepted; LEN+2 cycles per result.
// Backpressure: IN_READY drops from the last pair until OUT_READY takes the held result.
module dot_product_accumulator #(
  parameter int LEN   = 4,
  parameter int ACC_W = 40
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLEAR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [15:0]      A,
  input  logic [15:0]      B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [ACC_W-1:0] SUM,
  output logic             OVF
);

  localparam int CNT_W = $clog2(LEN);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      a_r;
  logic [15:0]      b_r;
  logic             v_r;
  logic [ACC_W-1:0] acc;
  logic [31:0]      p;
  logic [ACC_W:0]   acc_sum;
  logic             xfer;
  logic             last_pair;

  assign IN_READY  = (state == ST_ACCUM) && RST_N;
  assign xfer      = IN_VALID && IN_READY;
  assign last_pair = (cnt == CNT_W'(LEN - 1));
  // Top bit of the widened sum is the carry out of the accumulator.
  assign acc_sum   = {1'b0, acc} + (ACC_W + 1)'(p);

  Multiplier16x16 u_mult (
    .A (a_r),
    .B (b_r),
    .P (p)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_ACCUM;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      v_r       <= 1'b0;
      acc       <= '0;
      SUM       <= '0;
      OVF       <= 1'b0;
      OUT_VALID <= 1'b0;
    end else if (CLEAR) begin
      // Abort wins over any transfer or result on this edge; SUM keeps its last value.
      state     <= ST_ACCUM;
      cnt       <= '0;
      v_r       <= 1'b0;
      acc       <= '0;
      OVF       <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      v_r <= xfer;
      if (xfer) begin
        a_r <= A;
        b_r <= B;
        cnt <= last_pair ? '0 : cnt + 1'b1;
      end
      case (state)
        ST_ACCUM: begin
          if (v_r) begin
            acc <= acc_sum[ACC_W-1:0];
            OVF <= OVF | acc_sum[ACC_W];
          end
          if (xfer && last_pair) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          SUM       <= acc_sum[ACC_W-1:0];
          OVF       <= OVF | acc_sum[ACC_W];
          acc       <= '0;
          OUT_VALID <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            OVF       <= 1'b0;
            state     <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// Unsigned 16x16 -> 32 multiplier.
// Latency: combinational.
// Backpressure: none.
module Multiplier16x16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] P
);

  assign P = 32'(A) * 32'(B);

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench: two instances (ACC_W=40 and ACC_W=32) share one stimulus stream and
// are checked every cycle against a transaction-level model of the dot product.
module tb_dot_product_accumulator;

  logic        CLK;
  logic        RST_N;
  logic        CLEAR;
  logic        IN_VALID;
  logic [15:0] A;
  logic [15:0] B;
  logic        OUT_READY;

  logic        rdy40, vld40, ovf40;
  logic [39:0] sum40;
  logic        rdy32, vld32, ovf32;
  logic [31:0] sum32;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model state, index 0 = ACC_W 40, index 1 = ACC_W 32.
  int              aw       [2] = '{40, 32};
  int              n_pairs  [2];
  longint unsigned dot      [2];
  bit              have_res [2];
  longint unsigned res_sum  [2];
  bit              res_ovf  [2];
  int              due      [2];
  longint unsigned last_sum [2];
  int              dut_res  [2];

  dot_product_accumulator #(.LEN(4), .ACC_W(40)) u_dut40 (
    .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .IN_READY(rdy40),
    .A(A), .B(B), .OUT_VALID(vld40), .OUT_READY(OUT_READY), .SUM(sum40), .OVF(ovf40)
  );

  dot_product_accumulator #(.LEN(4), .ACC_W(32)) u_dut32 (
    .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .IN_READY(rdy32),
    .A(A), .B(B), .OUT_VALID(vld32), .OUT_READY(OUT_READY), .SUM(sum32), .OVF(ovf32)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", nm, cyc, got, exp);
    end
  endtask

  // Outputs are sampled on the falling edge; the model then predicts the next rising edge.
  always @(negedge CLK) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      logic            r_got, v_got, o_got;
      logic [63:0]     s_got;
      bit              exp_rdy, exp_vld;
      longint unsigned prod;
      r_got = (d == 0) ? rdy40 : rdy32;
      v_got = (d == 0) ? vld40 : vld32;
      o_got = (d == 0) ? ovf40 : ovf32;
      s_got = (d == 0) ? 64'(sum40) : 64'(sum32);
      if (!RST_N) begin
        n_pairs[d]  = 0;
        dot[d]      = 0;
        have_res[d] = 0;
        last_sum[d] = 0;
      end
      exp_rdy = RST_N && !have_res[d];
      exp_vld = RST_N && have_res[d] && (cyc >= due[d]);
      chk($sformatf("in_ready[%0d]", d), 64'(r_got), 64'(exp_rdy));
      chk($sformatf("out_valid[%0d]", d), 64'(v_got), 64'(exp_vld));
      if (exp_vld) begin
        chk($sformatf("sum[%0d]", d), s_got, res_sum[d]);
        chk($sformatf("ovf[%0d]", d), 64'(o_got), 64'(res_ovf[d]));
      end else begin
        chk($sformatf("sum_hold[%0d]", d), s_got, last_sum[d]);
      end
      if (!RST_N) chk($sformatf("ovf_rst[%0d]", d), 64'(o_got), 64'd0);
      if (RST_N && v_got && OUT_READY && !CLEAR) dut_res[d]++;

      if (RST_N) begin
        if (CLEAR) begin
          if (exp_vld) last_sum[d] = res_sum[d];
          n_pairs[d]  = 0;
          dot[d]      = 0;
          have_res[d] = 0;
        end else begin
          if (exp_vld && OUT_READY) begin
            have_res[d] = 0;
            last_sum[d] = res_sum[d];
          end
          if (exp_rdy && IN_VALID) begin
            prod = longint'(A) * longint'(B);
            dot[d] += prod;
            n_pairs[d]++;
            if (n_pairs[d] == 4) begin
              have_res[d] = 1;
              res_sum[d]  = dot[d] & ((64'd1 << aw[d]) - 1);
              res_ovf[d]  = (dot[d] >> aw[d]) != 0;
              due[d]      = cyc + 2;
              n_pairs[d]  = 0;
              dot[d]      = 0;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    bit ok;
    ok       = 0;
    IN_VALID = 1'b1;
    A        = a;
    B        = b;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (rdy40) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=in_ready_low expected=in_ready_high");
    end
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic wait_result(input string nm, input logic [63:0] e40, input logic e_ovf40,
                             input logic [63:0] e32, input logic e_ovf32);
    bit seen;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (vld40) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=out_valid_low expected=out_valid_high", nm);
    end else begin
      chk({nm, "_sum40"}, 64'(sum40), e40);
      chk({nm, "_ovf40"}, 64'(ovf40), 64'(e_ovf40));
      chk({nm, "_sum32"}, 64'(sum32), e32);
      chk({nm, "_ovf32"}, 64'(ovf32), 64'(e_ovf32));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      n_pairs[d] = 0; dot[d] = 0; have_res[d] = 0; res_sum[d] = 0;
      res_ovf[d] = 0; due[d] = 0; last_sum[d] = 0; dut_res[d] = 0;
    end
    RST_N     = 1'b0;
    CLEAR     = 1'b0;
    IN_VALID  = 1'b0;
    A         = '0;
    B         = '0;
    OUT_READY = 1'b1;
    idle(3);
    RST_N = 1'b1;
    step();

    send(3, 5); send(6, 10); send(9, 15); send(12, 20);
    wait_result("basic", 64'd450, 1'b0, 64'd450, 1'b0);
    step();

    // Gaps between pairs, then the result is held under backpressure.
    OUT_READY = 1'b0;
    send(3, 5); idle(2); send(6, 10); idle(1); send(9, 15); idle(3); send(12, 20);
    wait_result("gaps", 64'd450, 1'b0, 64'd450, 1'b0);
    step();
    IN_VALID = 1'b1; A = 16'h1234; B = 16'h5678;
    idle(10);
    chk("held_sum40", 64'(sum40), 64'd450);
    chk("held_vld40", 64'(vld40), 64'd1);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    step();

    repeat (4) send(16'hFFFF, 16'hFFFF);
    wait_result("max", 64'h3_FFF8_0004, 1'b0, 64'hFFF8_0004, 1'b1);
    step();

    repeat (4) send(1, 1);
    wait_result("ones", 64'd4, 1'b0, 64'd4, 1'b0);
    step();

    // Abort after two pairs; the pair offered on the abort edge is dropped.
    send(7, 7); send(7, 7);
    CLEAR = 1'b1; IN_VALID = 1'b1; A = 16'd50; B = 16'd50;
    step();
    CLEAR = 1'b0; IN_VALID = 1'b0;
    send(1, 1); send(2, 1); send(3, 1); send(4, 1);
    wait_result("clear", 64'd10, 1'b0, 64'd10, 1'b0);
    step();

    // Reset lands on the drain edge: the partial result must never appear.
    send(3, 5); send(6, 10); send(9, 15); send(12, 20);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    idle(3);
    chk("rst_drain_vld40", 64'(vld40), 64'd0);
    send(3, 5); send(6, 10); send(9, 15); send(12, 20);
    wait_result("after_rst", 64'd450, 1'b0, 64'd450, 1'b0);
    step();
    idle(2);

    chk("results40", 64'(dut_res[0]), 64'd6);
    chk("results32", 64'(dut_res[1]), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
